uart_transmitter: RTL and testbench

UART serial transmitter, 8N1 framing (1 start, BYTE_WIDTH data bits LSB first, 1 stop). Paced by the shared 16x oversampling tick from the baud rate generator: each bit is held for 16 ticks. Accepts a byte from the core (program loader / Fibonacci result path) via a valid/ready handshake and drives the tx line to the host's UART receiver. Buffers one pending byte so back-to-back frames leave no idle gap.

---
 rtl/uart_transmitter.sv | 153 +++++++++++++++
 tb/tb_uart_transmitter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART 8N1 transmitter paced by a shared oversampling tick, with a one-byte
// holding buffer so consecutive frames run back to back without an idle bit.
module uart_transmitter #(
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  tick,
    input  logic                  tx_valid,
    input  logic [BYTE_WIDTH-1:0] data_in,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(BYTE_WIDTH) + 1;

    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(BYTE_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [TickW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [BYTE_WIDTH-1:0] shift_q, shift_d;
    logic [BYTE_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic                  tx_q, tx_d;
    logic                  tx_done_q, tx_done_d;

    logic bit_end;
    logic accept;

    assign bit_end = tick && (tick_cnt_q == TickLast);
    // Readiness comes from the registered buffer flag only: no same-cycle fall-through.
    assign accept  = tx_valid && !buf_full_q;

    // Next-state, counter, shifter and holding-buffer logic.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        tx_done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Start immediately; the start bit is timed from this load.
                if (buf_full_q) begin
                    shift_d    = buf_q;
                    buf_full_d = 1'b0;
                    tick_cnt_d = '0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = StData;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_cnt_q == BitLast) begin
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    tx_done_d  = 1'b1;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (buf_full_q) begin
                        shift_d    = buf_q;
                        buf_full_d = 1'b0;
                        state_d    = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Unload needs a full buffer and accept needs an empty one, so they never collide.
        if (accept) begin
            buf_d      = data_in;
            buf_full_d = 1'b1;
        end
    end

    // Line level for the next cycle, derived from the next state so tx comes from a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame and drops the buffered byte.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_done  = tx_done_q;
    assign tx_ready = !buf_full_q;
    assign tx_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: frame-level reference model plus
// tick-indexed line sampling for literal bit checks.
module tb_uart_transmitter;

    localparam int BW = 8;
    localparam int OS = 16;
    localparam int FL = (BW + 2) * OS;

    logic          clk;
    logic          arst_n;
    logic          tick;
    logic          tx_valid;
    logic [BW-1:0] data_in;
    logic          tx_ready;
    logic          tx;
    logic          tx_busy;
    logic          tx_done;

    uart_transmitter #(
        .BYTE_WIDTH(BW),
        .OVERSAMPLE(OS)
    ) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .tick    (tick),
        .tx_valid(tx_valid),
        .data_in (data_in),
        .tx_ready(tx_ready),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: current frame as a bit vector plus ticks elapsed in it.
    typedef struct {
        bit            active;
        logic [BW+1:0] frame;
        int            pos;
        bit            pend;
        logic [BW-1:0] pend_b;
        bit            done;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.active = 0;
        r.frame  = '1;
        r.pos    = 0;
        r.pend   = 0;
        r.pend_b = '0;
        r.done   = 0;
        return r;
    endfunction

    function automatic model_t model_step(model_t c, logic tk, logic v, logic [BW-1:0] d);
        model_t n = c;
        bit rdy = !c.pend;
        n.done = 0;
        if (!c.active) begin
            if (c.pend) begin
                n.active = 1;
                n.frame  = {1'b1, c.pend_b, 1'b0};
                n.pos    = 0;
                n.pend   = 0;
            end
        end else if (tk) begin
            n.pos = c.pos + 1;
            if (n.pos == FL) begin
                n.done = 1;
                n.pos  = 0;
                if (c.pend) begin
                    n.frame = {1'b1, c.pend_b, 1'b0};
                    n.pend  = 0;
                end else begin
                    n.active = 0;
                end
            end
        end
        if (v && rdy) begin
            n.pend   = 1;
            n.pend_b = d;
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Clock.
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Tick generator: periodic, random or held off.
    bit tick_on   = 1;
    bit tick_rand = 0;
    int tick_div  = 4;
    int tick_ph   = 0;
    initial begin
        tick = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!tick_on) begin
                tick = 0;
            end else if (tick_rand) begin
                tick = ($urandom_range(0, 1) == 1);
            end else begin
                tick_ph = (tick_ph + 1) % tick_div;
                tick    = (tick_ph == 0);
            end
        end
    end

    // Model update on every edge, asynchronous reset included.
    initial begin
        m = model_reset();
        forever begin
            @(posedge clk or negedge arst_n);
            if (!arst_n) m = model_reset();
            else m = model_step(m, tick, tx_valid, data_in);
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("tx", int'(tx), m.active ? int'(m.frame[m.pos / OS]) : 1);
            check("tx_busy", int'(tx_busy), int'(m.active));
            check("tx_ready", int'(tx_ready), int'(!m.pend));
            check("tx_done", int'(tx_done), int'(m.done));
        end
    end

    // Line monitor: samples tx on each counted tick, counts done pulses and busy falls.
    logic samp [0:FL*4-1];
    int   busy_ticks = 0;
    int   done_cnt   = 0;
    int   busy_falls = 0;
    logic prev_busy  = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (tick && tx_busy) begin
                if (busy_ticks < FL * 4) samp[busy_ticks] = tx;
                busy_ticks++;
            end
            if (tx_done) done_cnt++;
            if (prev_busy && !tx_busy) busy_falls++;
            prev_busy = tx_busy;
        end
    end

    task automatic clear_mon();
        busy_ticks = 0;
        done_cnt   = 0;
        busy_falls = 0;
    endtask

    task automatic offer(input logic [BW-1:0] b, input int max, input string name);
        bit r;
        tx_valid = 1;
        data_in  = b;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            r = tx_ready;
            @(posedge clk);
            #1;
            if (r) begin
                tx_valid = 0;
                data_in  = BW'($urandom);
                return;
            end
        end
        tx_valid = 0;
        timeout(name);
    endtask

    task automatic wait_idle(input int max, input string name);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!tx_busy && tx_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        timeout(name);
        @(posedge clk);
        #1;
    endtask

    // Checks the sampled mid-bit line levels of frame f against byte b.
    task automatic check_frame(input string name, input int f, input logic [BW-1:0] b);
        logic [BW+1:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < BW + 2; k++) check(name, int'(samp[f * FL + k * OS + OS / 2]), int'(fr[k]));
    endtask

    logic [9:0] a5_lit;

    initial begin
        arst_n   = 1;
        tx_valid = 0;
        data_in  = '0;
        #1 arst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", int'(tx), 1);
        check("reset_ready", int'(tx_ready), 1);
        check("reset_busy", int'(tx_busy), 0);
        check("reset_done", int'(tx_done), 0);
        #2 arst_n = 1;
        @(posedge clk);
        #1;

        // Single byte 0xA5 with a tick every 4 clocks.
        clear_mon();
        offer(8'hA5, 10, "a5_accept");
        wait_idle(2000, "a5_idle");
        check("a5_done_pulses", done_cnt, 1);
        check("a5_busy_ticks", busy_ticks, 160);
        check("a5_busy_falls", busy_falls, 1);
        a5_lit = 10'b1_1010_0101_0;
        for (int k = 0; k < 10; k++) check("a5_bit", int'(samp[k * 16 + 8]), int'(a5_lit[k]));

        // Back-to-back 0x55, 0x0F, then 0x99 offered against a full buffer.
        clear_mon();
        offer(8'h55, 10, "b2b_first");
        offer(8'h0F, 10, "b2b_second");
        @(negedge clk);
        check("b2b_ready_low", int'(tx_ready), 0);
        @(posedge clk);
        #1;
        offer(8'h99, 2000, "b2b_third");
        check("b2b_third_accept_time", busy_ticks, 160);
        wait_idle(6000, "b2b_idle");
        check("b2b_done_pulses", done_cnt, 3);
        check("b2b_busy_ticks", busy_ticks, 480);
        check("b2b_no_gap", busy_falls, 1);
        check_frame("b2b_f0", 0, 8'h55);
        check_frame("b2b_f1", 1, 8'h0F);
        check_frame("b2b_f2", 2, 8'h99);

        // 0x00, 0xFF, 0x3C under random tick spacing.
        tick_rand = 1;
        clear_mon();
        offer(8'h00, 10, "rnd_b0");
        offer(8'hFF, 10, "rnd_b1");
        offer(8'h3C, 2000, "rnd_b2");
        wait_idle(6000, "rnd_idle");
        check("rnd_done_pulses", done_cnt, 3);
        check_frame("rnd_f0", 0, 8'h00);
        check_frame("rnd_f1", 1, 8'hFF);
        check_frame("rnd_f2", 2, 8'h3C);
        tick_rand = 0;

        // Reset in the middle of 0xC3's data bits with a byte buffered behind it.
        clear_mon();
        offer(8'hC3, 10, "rst_c3");
        offer(8'h77, 10, "rst_77");
        begin
            bit reached = 0;
            for (int i = 0; i < 1000 && !reached; i++) begin
                @(posedge clk);
                #1;
                if (busy_ticks >= 58) reached = 1;
            end
            if (!reached) timeout("rst_reach_data");
        end
        check("rst_pre_tx", int'(tx), 0);
        @(posedge clk);
        #3 arst_n = 0;
        #1;
        check("rst_async_tx", int'(tx), 1);
        check("rst_async_busy", int'(tx_busy), 0);
        check("rst_async_ready", int'(tx_ready), 1);
        repeat (2) @(posedge clk);
        #3 arst_n = 1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_buffer_dropped", int'(tx_busy), 0);
        clear_mon();
        offer(8'h81, 10, "rst_81");
        wait_idle(2000, "rst_81_idle");
        check("rst_81_done", done_cnt, 1);
        check_frame("rst_81", 0, 8'h81);

        // Ticks withheld for 100 clocks during the start bit.
        clear_mon();
        tick_on = 0;
        offer(8'h6B, 10, "hold_accept");
        repeat (100) @(posedge clk);
        #1;
        check("hold_tx", int'(tx), 0);
        check("hold_busy", int'(tx_busy), 1);
        check("hold_ticks", busy_ticks, 0);
        tick_on = 1;
        wait_idle(2000, "hold_idle");
        check("hold_done", done_cnt, 1);
        check_frame("hold", 0, 8'h6B);

        // Randomized valid/data traffic with random tick spacing.
        tick_rand = 1;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            #1;
            tx_valid = ($urandom_range(0, 3) == 0);
            data_in  = BW'($urandom);
        end
        tx_valid = 0;
        wait_idle(4000, "rand_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
